// File: rtl/prienc_seq.sv
// Registered priority encoder with serialiser: captures a request vector and
// emits the index of each set bit, highest first, one per valid/ready handshake.
module prienc_seq #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  input  logic         req_load,
  input  logic         enc_ready,
  output logic [W-1:0] enc_out,
  output logic         enc_valid,
  output logic         busy,
  output logic         done,
  output logic         none_flag
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state_q;
  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;
  logic [W-1:0] enc_out_q;
  logic         enc_valid_q;
  logic         busy_q;
  logic         done_q;
  logic         none_q;

  // Index of the highest set bit; later (higher) bits overwrite earlier ones.
  function automatic logic [W-1:0] prio(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // Pending mask with the index currently on enc_out retired.
  always_comb begin
    pend_d = pend_q & ~(N'(1) << enc_out_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      enc_out_q   <= '0;
      enc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      none_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      none_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_load) begin
            if (req_in != '0) begin
              pend_q      <= req_in;
              enc_out_q   <= prio(req_in);
              enc_valid_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= EMIT;
            end else begin
              done_q <= 1'b1;
              none_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (enc_valid_q && enc_ready) begin
            if (pend_d != '0) begin
              pend_q    <= pend_d;
              enc_out_q <= prio(pend_d);
            end else begin
              // Last index accepted; enc_out keeps its final value.
              pend_q      <= '0;
              enc_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enc_out   = enc_out_q;
  assign enc_valid = enc_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign none_flag = none_q;

endmodule

// File: tb/tb_prienc_seq.sv
// Self-checking bench for prienc_seq: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, and a randomized phase.
module tb_prienc_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_in;
  logic       req_load;
  logic       enc_ready;
  logic [1:0] enc_out;
  logic       enc_valid, busy, done, none_flag;

  logic [7:0] req_in8;
  logic       req_load8, enc_ready8;
  logic [2:0] enc_out8;
  logic       enc_valid8, busy8, done8, none8;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  prienc_seq #(.N(4), .W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .req_load(req_load),
    .enc_ready(enc_ready), .enc_out(enc_out), .enc_valid(enc_valid),
    .busy(busy), .done(done), .none_flag(none_flag)
  );

  prienc_seq #(.N(8), .W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_in(req_in8), .req_load(req_load8),
    .enc_ready(enc_ready8), .enc_out(enc_out8), .enc_valid(enc_valid8),
    .busy(busy8), .done(done8), .none_flag(none8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the loaded vector becomes a queue of indices, highest first.
  int       mq[$];
  logic [1:0] m_out   = '0;
  bit       m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_none = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_out = '0; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_none = 1'b0;
    end else begin
      m_done = 1'b0;
      m_none = 1'b0;
      if (!m_busy) begin
        if (req_load) begin
          if (req_in == 4'd0) begin
            m_done = 1'b1;
            m_none = 1'b1;
          end else begin
            for (int i = 3; i >= 0; i--) if (req_in[i]) mq.push_back(i);
            m_out   = 2'(mq[0]);
            m_valid = 1'b1;
            m_busy  = 1'b1;
          end
        end
      end else if (enc_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_valid = 1'b0;
          m_busy  = 1'b0;
          m_done  = 1'b1;
        end else begin
          m_out = 2'(mq[0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_enc_out",   32'(enc_out),   32'(m_out));
      chk("model_enc_valid", 32'(enc_valid), 32'(m_valid));
      chk("model_busy",      32'(busy),      32'(m_busy));
      chk("model_done",      32'(done),      32'(m_done));
      chk("model_none",      32'(none_flag), 32'(m_none));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect4(input string name, input logic [1:0] o, input logic v,
                         input logic b, input logic d, input logic n);
    chk({name, "_out"},   32'(enc_out),   32'(o));
    chk({name, "_valid"}, 32'(enc_valid), 32'(v));
    chk({name, "_busy"},  32'(busy),      32'(b));
    chk({name, "_done"},  32'(done),      32'(d));
    chk({name, "_none"},  32'(none_flag), 32'(n));
  endtask

  initial begin
    rst_n = 1'b0; req_load = 1'b1; req_in = 4'hF; enc_ready = 1'b0;
    req_load8 = 1'b0; req_in8 = '0; enc_ready8 = 1'b0;

    // Reset held for two edges with a load pending
    step(); step();
    chk_en = 1'b1;
    expect4("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; req_load = 1'b0; req_in = '0;
    step();
    expect4("post_reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 1010 with ready high: 3, 1, done
    req_load = 1'b1; req_in = 4'b1010; enc_ready = 1'b1;
    step(); req_load = 1'b0;
    expect4("t2_a", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    expect4("t2_b", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    expect4("t2_done", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();

    // 1001 with ready low for three edges
    req_load = 1'b1; req_in = 4'b1001; enc_ready = 1'b0;
    step(); req_load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect4("t3_hold", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 4) enc_ready = 1'b1;
      step();
    end
    expect4("t3_b", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    expect4("t3_done", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();

    // All-zero load
    req_load = 1'b1; req_in = 4'b0000;
    step(); req_load = 1'b0;
    expect4("t4_none", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    expect4("t4_clear", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Loads during EMIT ignored; load in the done cycle accepted
    req_load = 1'b1; req_in = 4'b0110; enc_ready = 1'b1;
    step(); req_in = 4'b1000;
    expect4("t5_a", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    expect4("t5_b", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    expect4("t5_done", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); req_load = 1'b0;
    expect4("t5_reload", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    expect4("t5_done2", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-EMIT
    req_load = 1'b1; req_in = 4'b1111; enc_ready = 1'b1;
    step(); req_load = 1'b0;
    expect4("t6_a", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(); rst_n = 1'b1;
    expect4("t6_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect4("t6_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // N=8 instance: 8'h81 emits 7 then 0
    req_load8 = 1'b1; req_in8 = 8'h81; enc_ready8 = 1'b1;
    step(); req_load8 = 1'b0;
    chk("n8_a_out", 32'(enc_out8), 32'd7);
    chk("n8_a_valid", 32'(enc_valid8), 32'd1);
    step();
    chk("n8_b_out", 32'(enc_out8), 32'd0);
    chk("n8_b_valid", 32'(enc_valid8), 32'd1);
    step();
    chk("n8_done", 32'(done8), 32'd1);
    chk("n8_valid_off", 32'(enc_valid8), 32'd0);
    chk("n8_busy_off", 32'(busy8), 32'd0);

    // Randomized phase, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      req_load  = ($urandom_range(0, 9) < 4);
      req_in    = 4'($urandom_range(0, 15));
      enc_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
